fan_ctrl_sched: RTL and testbench
=================================

# fan_ctrl_sched

Sequencing controller in front of the forwarding-adder network (FAN) used for unstructured sparse row reduction. It accepts beats of NUM_IN lane products with row indices and computes each lane's segment control bits (pending, complete, first, last). It issues the beats into a FAN pipeline of fixed LATENCY and captures the FAN results into an output FIFO. Admission is credit-based because the FAN cannot stall, and a flush handshake drains the pipeline.

## Interface
- DW_DATA, 8, data width per lane
- DW_ROW, 4, row-index width
- DW_CTRL, 4, control width (fixed at 4)
- DW_LINE, DW_DATA+DW_ROW+DW_CTRL, lane word = {ctrl, row, data}
- NUM_IN, 8, lanes per beat (power of two, ≥2)
- LATENCY, 3, FAN pipeline depth in cycles (≥1)
- FIFO_DEPTH, 4, output FIFO entries (≥2)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  beat offered
- in_ready  out  1  beat accepted when in_valid&in_ready
- in_lane_valid  in  NUM_IN  per-lane nonzero flag
- in_row  in  NUM_IN*DW_ROW  per-lane row index
- in_data  in  NUM_IN*DW_DATA  per-lane product
- fan_in  out  NUM_IN*DW_LINE  issued lane words to FAN
- fan_out  in  NUM_IN*DW_LINE  FAN result lanes
- out_valid  out  1  FIFO head valid
- out_ready  in  1  consumer pops head
- out_line  out  NUM_IN*DW_LINE  head result lanes
- out_mask  out  NUM_IN  head lanes with ctrl[2]=1 (completed sums)
- flush  in  1  request drain
- flush_done  out  1  one-cycle pulse, drain complete
- busy  out  1  inflight≠0 or FIFO non-empty

## Operation
- Control encoding: ctrl[3] = pending reduction, ctrl[2] = complete, ctrl[1] = last of segment, ctrl[0] = first of segment.
- Segment definition: a maximal run of adjacent valid lanes with equal row index.
  - first_i = v_i & (i==0 | !v_{i-1} | row_{i-1}≠row_i)
  - last_i = v_i & (i==NUM_IN-1 | !v_{i+1} | row_{i+1}≠row_i)
- Lane ctrl:
  - invalid lane → 4'b0000, and the whole lane word is zero.
  - valid lane with first&last (singleton) → 4'b0111.
  - otherwise → {1, 0, last, first}.
- Issue register: an accepted beat loads fan_in. With no accept, fan_in is loaded with all zeros, so the FAN bypasses zeros.
- Delay line: a LATENCY+1-deep valid shift register tags which fan_out cycles carry a real beat. Only tagged cycles are written into the FIFO; untagged fan_out is ignored.
- Credits:
  - inflight = tags set in the delay line.
  - in_ready = (state==RUN) & (inflight + fifo_count < FIFO_DEPTH). This guarantees a FIFO slot for every issued beat.
- FIFO: registered output. out_mask is derived from the stored ctrl[2] bits. Push and pop in the same cycle are allowed; count is unchanged.
- FSM:
  - RUN: normal operation. flush=1 → DRAIN.
  - DRAIN: in_ready=0. When inflight==0 and FIFO is empty → DONE.
  - DONE: flush_done=1 for one cycle, then → RUN.
- flush asserted while in DRAIN or DONE is ignored. flush with nothing in flight still passes through DRAIN→DONE (minimum 2 cycles).
- Counter widths: $clog2(FIFO_DEPTH+1). Adders within the FAN wrap modulo 2^DW_DATA; this block does not alter data.

## Timing
- Reset values: fan_in=0, delay line=0, FIFO empty, out_valid=0, out_line=0, out_mask=0, flush_done=0, busy=0, state=RUN. in_ready=1 once rst deasserts.
- Beat accepted at edge t:
  - appears on fan_in after edge t.
  - tagged fan_out is sampled at edge t+1+LATENCY.
  - out_valid=1 after edge t+1+LATENCY (LATENCY+2 cycles from accept to visible output).
- Back-to-back accepts: one beat per cycle while credits allow. A full pipeline with no pops stalls after FIFO_DEPTH accepts.
- Reset mid-operation discards all in-flight beats and FIFO contents immediately (asynchronous). No flush_done is produced.

## Structure
- Shared package fan_pkg:
  - DW_DATA/DW_ROW/DW_CTRL defaults
  - ctrl bit positions (CTRL_PEND=3, CTRL_DONE=2, CTRL_LAST=1, CTRL_FIRST=0)
  - constants CTRL_SINGLE=4'b0111, CTRL_IDLE=4'b0000
  - FSM state encoding
- Sub-module fan_seg_mark (combinational first/last/ctrl generation per beat). The FIFO is written inline.

## Test plan
- Rows {0,0,1,1,1,2,3,3}, all lanes valid, data 1..8 → fan_in ctrl lanes 0..7 = 1001,1010,1001,1000,1010,0111,1001,1010.
- in_lane_valid=8'b1111_0110, rows all 5 → lanes 0,3 ctrl 0000 with zero word; lanes 1,2 = 1001,1010; lanes 4..7 = 1001,1000,1000,1010.
- Single beat accepted at cycle 10, LATENCY=3, bench FAN modelled as a 3-cycle delay → out_valid first high after edge 14; out_mask = lanes with ctrl[2] set.
- out_ready=0, in_valid held high → exactly 4 accepts, then in_ready=0. Raise out_ready → one pop per cycle and in_ready reasserts the cycle after the first pop.
- Issue 2 beats then flush=1 → in_ready=0 during DRAIN. After both beats are popped, flush_done pulses for 1 cycle and in_ready returns to 1.
- Assert rst asynchronously with 3 beats in flight → out_valid, busy and fan_in go 0 immediately; no result is delivered after release.

Source files
------------

// File: rtl/fan_pkg.sv
// Shared definitions for the FAN sequencing controller: default widths,
// lane control bit positions, control constants and FSM encoding.
package fan_pkg;

  localparam int DEF_DW_DATA = 8;
  localparam int DEF_DW_ROW  = 4;
  localparam int DEF_DW_CTRL = 4;

  localparam int CTRL_PEND  = 3;
  localparam int CTRL_DONE  = 2;
  localparam int CTRL_LAST  = 1;
  localparam int CTRL_FIRST = 0;

  localparam logic [3:0] CTRL_SINGLE = 4'b0111;
  localparam logic [3:0] CTRL_IDLE   = 4'b0000;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } fan_state_t;

  // Lane control word from the lane's valid flag and its segment boundaries.
  // A singleton segment needs no reduction, so it is marked complete at issue.
  function automatic logic [3:0] lane_ctrl(input logic valid, input logic first, input logic last);
    logic [3:0] c;
    c = CTRL_IDLE;
    if (!valid) begin
      c = CTRL_IDLE;
    end else if (first && last) begin
      c = CTRL_SINGLE;
    end else begin
      c             = CTRL_IDLE;
      c[CTRL_PEND]  = 1'b1;
      c[CTRL_LAST]  = last;
      c[CTRL_FIRST] = first;
    end
    return c;
  endfunction

endpackage

// File: rtl/fan_seg_mark.sv
// Combinational segment marker: for one beat, finds runs of adjacent valid
// lanes sharing a row index and builds the {ctrl, row, data} lane words.
// Invalid lanes produce an all-zero word.
module fan_seg_mark
  import fan_pkg::*;
#(
  parameter int DW_DATA = DEF_DW_DATA,
  parameter int DW_ROW  = DEF_DW_ROW,
  parameter int DW_CTRL = DEF_DW_CTRL,
  parameter int DW_LINE = DW_DATA + DW_ROW + DW_CTRL,
  parameter int NUM_IN  = 8
) (
  input  logic [NUM_IN-1:0]         lane_valid,
  input  logic [NUM_IN*DW_ROW-1:0]  row,
  input  logic [NUM_IN*DW_DATA-1:0] data,
  output logic [NUM_IN*DW_LINE-1:0] lane_word
);

  for (genvar i = 0; i < NUM_IN; i++) begin : g_lane
    logic               brk_prev_s;
    logic               brk_next_s;
    logic               first_s;
    logic               last_s;
    logic [DW_CTRL-1:0] ctrl_s;
    logic [DW_ROW-1:0]  row_s;

    assign row_s = row[i*DW_ROW +: DW_ROW];

    // A segment starts at lane 0 or after an invalid lane / row change.
    if (i == 0) begin : g_head
      assign brk_prev_s = 1'b1;
    end else begin : g_prev
      assign brk_prev_s = !lane_valid[i-1] || (row[(i-1)*DW_ROW +: DW_ROW] != row_s);
    end

    // A segment ends at the top lane or before an invalid lane / row change.
    if (i == NUM_IN - 1) begin : g_tail
      assign brk_next_s = 1'b1;
    end else begin : g_next
      assign brk_next_s = !lane_valid[i+1] || (row[(i+1)*DW_ROW +: DW_ROW] != row_s);
    end

    assign first_s = lane_valid[i] & brk_prev_s;
    assign last_s  = lane_valid[i] & brk_next_s;
    assign ctrl_s  = lane_ctrl(lane_valid[i], first_s, last_s);

    assign lane_word[i*DW_LINE +: DW_LINE] = lane_valid[i]
                                           ? {ctrl_s, row_s, data[i*DW_DATA +: DW_DATA]}
                                           : {DW_LINE{1'b0}};
  end

endmodule

// File: rtl/fan_ctrl_sched.sv
// FAN sequencing controller: marks segments, issues beats into a fixed-latency
// FAN pipeline, tags the real beats in a delay line and captures tagged FAN
// results into an output FIFO. Admission is credit based so the FAN never has
// to stall; a flush handshake drains the pipeline and FIFO.
module fan_ctrl_sched
  import fan_pkg::*;
#(
  parameter int DW_DATA    = DEF_DW_DATA,
  parameter int DW_ROW     = DEF_DW_ROW,
  parameter int DW_CTRL    = DEF_DW_CTRL,
  parameter int DW_LINE    = DW_DATA + DW_ROW + DW_CTRL,
  parameter int NUM_IN     = 8,
  parameter int LATENCY    = 3,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [NUM_IN-1:0]         in_lane_valid,
  input  logic [NUM_IN*DW_ROW-1:0]  in_row,
  input  logic [NUM_IN*DW_DATA-1:0] in_data,
  output logic [NUM_IN*DW_LINE-1:0] fan_in,
  input  logic [NUM_IN*DW_LINE-1:0] fan_out,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [NUM_IN*DW_LINE-1:0] out_line,
  output logic [NUM_IN-1:0]         out_mask,
  input  logic                      flush,
  output logic                      flush_done,
  output logic                      busy
);

  localparam int W_BEAT = NUM_IN * DW_LINE;
  localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  // Wide enough to hold inflight + fifo_count without wrapping.
  localparam int SUM_W  = $clog2(LATENCY + FIFO_DEPTH + 2);

  fan_state_t          state_r;
  logic                flush_done_r;
  logic [W_BEAT-1:0]   fan_in_r;
  logic [LATENCY:0]    tag_r;
  logic [W_BEAT-1:0]   mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_r;
  logic [PTR_W-1:0]    rd_ptr_r;
  logic [CNT_W-1:0]    count_r;
  logic                out_valid_r;
  logic [W_BEAT-1:0]   out_line_r;
  logic [NUM_IN-1:0]   out_mask_r;

  logic [W_BEAT-1:0]   seg_word_s;
  logic [SUM_W-1:0]    inflight_s;
  logic                credit_ok_s;
  logic                accept_s;
  logic                push_s;
  logic                pop_s;
  logic [CNT_W-1:0]    count_nx_s;
  logic [CNT_W-1:0]    remain_s;
  logic [PTR_W-1:0]    rd_ptr_nx_s;
  logic [W_BEAT-1:0]   head_nx_s;
  logic [NUM_IN-1:0]   mask_nx_s;

  // Circular pointer advance for a FIFO depth that need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(FIFO_DEPTH - 1)) begin
      return '0;
    end else begin
      return p + 1'b1;
    end
  endfunction

  fan_seg_mark #(
    .DW_DATA (DW_DATA),
    .DW_ROW  (DW_ROW),
    .DW_CTRL (DW_CTRL),
    .DW_LINE (DW_LINE),
    .NUM_IN  (NUM_IN)
  ) u_seg_mark (
    .lane_valid (in_lane_valid),
    .row        (in_row),
    .data       (in_data),
    .lane_word  (seg_word_s)
  );

  // Count beats still travelling through the FAN (set tags in the delay line).
  always_comb begin
    inflight_s = '0;
    for (int k = 0; k <= LATENCY; k++) begin
      inflight_s = inflight_s + SUM_W'(tag_r[k]);
    end
  end

  // Every beat admitted must already own a FIFO slot when it leaves the FAN.
  assign credit_ok_s = (inflight_s + SUM_W'(count_r)) < SUM_W'(FIFO_DEPTH);
  assign in_ready    = (state_r == ST_RUN) && credit_ok_s;
  assign accept_s    = in_valid && in_ready;
  assign pop_s       = out_valid_r && out_ready;
  assign push_s      = tag_r[LATENCY] && ((count_r != CNT_W'(FIFO_DEPTH)) || pop_s);

  // FIFO next-state: occupancy, read pointer and the head word seen after the edge.
  always_comb begin
    count_nx_s  = count_r;
    rd_ptr_nx_s = rd_ptr_r;
    remain_s    = count_r;
    head_nx_s   = '0;
    mask_nx_s   = '0;
    if (push_s && !pop_s) begin
      count_nx_s = count_r + 1'b1;
    end else if (!push_s && pop_s) begin
      count_nx_s = count_r - 1'b1;
    end else begin
      count_nx_s = count_r;
    end
    if (pop_s) begin
      rd_ptr_nx_s = ptr_inc(rd_ptr_r);
      remain_s    = count_r - 1'b1;
    end else begin
      rd_ptr_nx_s = rd_ptr_r;
      remain_s    = count_r;
    end
    // When nothing older remains, the incoming word becomes the head directly.
    if (remain_s != '0) begin
      head_nx_s = mem_r[rd_ptr_nx_s];
    end else if (push_s) begin
      head_nx_s = fan_out;
    end else begin
      head_nx_s = '0;
    end
    for (int k = 0; k < NUM_IN; k++) begin
      mask_nx_s[k] = head_nx_s[k*DW_LINE + DW_DATA + DW_ROW + CTRL_DONE];
    end
  end

  // Issue register: accepted beat goes to the FAN, otherwise feed zeros.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fan_in_r <= '0;
    end else if (accept_s) begin
      fan_in_r <= seg_word_s;
    end else begin
      fan_in_r <= '0;
    end
  end

  // Delay line tagging which FAN output cycles carry a real beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_r <= '0;
    end else begin
      tag_r <= {tag_r[LATENCY-1:0], accept_s};
    end
  end

  // Output FIFO storage, pointers and registered head outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < FIFO_DEPTH; k++) begin
        mem_r[k] <= '0;
      end
      wr_ptr_r    <= '0;
      rd_ptr_r    <= '0;
      count_r     <= '0;
      out_valid_r <= 1'b0;
      out_line_r  <= '0;
      out_mask_r  <= '0;
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= fan_out;
        wr_ptr_r        <= ptr_inc(wr_ptr_r);
      end
      rd_ptr_r    <= rd_ptr_nx_s;
      count_r     <= count_nx_s;
      out_valid_r <= (count_nx_s != '0);
      out_line_r  <= head_nx_s;
      out_mask_r  <= mask_nx_s;
    end
  end

  // Flush FSM: RUN -> DRAIN on request, DRAIN -> DONE when empty, DONE pulses once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= ST_RUN;
      flush_done_r <= 1'b0;
    end else begin
      case (state_r)
        ST_RUN: begin
          flush_done_r <= 1'b0;
          if (flush) begin
            state_r <= ST_DRAIN;
          end else begin
            state_r <= ST_RUN;
          end
        end
        ST_DRAIN: begin
          if ((inflight_s == '0) && (count_r == '0)) begin
            state_r      <= ST_DONE;
            flush_done_r <= 1'b1;
          end else begin
            state_r      <= ST_DRAIN;
            flush_done_r <= 1'b0;
          end
        end
        ST_DONE: begin
          state_r      <= ST_RUN;
          flush_done_r <= 1'b0;
        end
        default: begin
          state_r      <= ST_RUN;
          flush_done_r <= 1'b0;
        end
      endcase
    end
  end

  assign fan_in     = fan_in_r;
  assign out_valid  = out_valid_r;
  assign out_line   = out_line_r;
  assign out_mask   = out_mask_r;
  assign flush_done = flush_done_r;
  assign busy       = (inflight_s != '0) || (count_r != '0);

endmodule

// File: tb/tb_fan_ctrl_sched.sv
// Self-checking bench for fan_ctrl_sched. A transaction-level model (segment
// scan per beat, queue of outstanding beats with ready times, flush phases)
// predicts every output each cycle; the FAN is a plain LATENCY-stage delay.
module tb_fan_ctrl_sched;

  localparam int DW_DATA    = 8;
  localparam int DW_ROW     = 4;
  localparam int DW_CTRL    = 4;
  localparam int DW_LINE    = DW_DATA + DW_ROW + DW_CTRL;
  localparam int NUM_IN     = 8;
  localparam int LATENCY    = 3;
  localparam int FIFO_DEPTH = 4;
  localparam int W_BEAT     = NUM_IN * DW_LINE;

  localparam int M_RUN   = 0;
  localparam int M_DRAIN = 1;
  localparam int M_DONE  = 2;

  logic                      clk;
  logic                      rst;
  logic                      in_valid;
  logic                      in_ready;
  logic [NUM_IN-1:0]         in_lane_valid;
  logic [NUM_IN*DW_ROW-1:0]  in_row;
  logic [NUM_IN*DW_DATA-1:0] in_data;
  logic [W_BEAT-1:0]         fan_in;
  logic [W_BEAT-1:0]         fan_out;
  logic                      out_valid;
  logic                      out_ready;
  logic [W_BEAT-1:0]         out_line;
  logic [NUM_IN-1:0]         out_mask;
  logic                      flush;
  logic                      flush_done;
  logic                      busy;

  fan_ctrl_sched #(
    .DW_DATA    (DW_DATA),
    .DW_ROW     (DW_ROW),
    .DW_CTRL    (DW_CTRL),
    .DW_LINE    (DW_LINE),
    .NUM_IN     (NUM_IN),
    .LATENCY    (LATENCY),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_lane_valid (in_lane_valid),
    .in_row        (in_row),
    .in_data       (in_data),
    .fan_in        (fan_in),
    .fan_out       (fan_out),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_line      (out_line),
    .out_mask      (out_mask),
    .flush         (flush),
    .flush_done    (flush_done),
    .busy          (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // FAN stand-in: fixed LATENCY-cycle delay of the issued words.
  logic [W_BEAT-1:0] fan_pipe [LATENCY];
  initial begin
    for (int k = 0; k < LATENCY; k++) fan_pipe[k] = '0;
  end
  always @(posedge clk) begin
    fan_pipe[0] <= fan_in;
    for (int k = 1; k < LATENCY; k++) fan_pipe[k] <= fan_pipe[k-1];
  end
  assign fan_out = fan_pipe[LATENCY-1];

  // ---------------- reference model ----------------
  typedef struct {
    int                rdy;
    logic [W_BEAT-1:0] word;
  } ent_t;

  ent_t              q[$];
  int                m_st;
  int                now;
  logic [W_BEAT-1:0] exp_fan_in;
  int                n_vec;
  int                n_err;

  function automatic logic [W_BEAT-1:0] ref_line(input logic [NUM_IN-1:0] lv,
                                                 input logic [NUM_IN*DW_ROW-1:0] rw,
                                                 input logic [NUM_IN*DW_DATA-1:0] dt);
    logic [W_BEAT-1:0] w;
    logic [3:0]        c;
    int                i;
    int                j;
    w = '0;
    i = 0;
    while (i < NUM_IN) begin
      if (!lv[i]) begin
        i++;
      end else begin
        j = i;
        while ((j + 1 < NUM_IN) && lv[j+1] && (rw[(j+1)*DW_ROW +: DW_ROW] == rw[i*DW_ROW +: DW_ROW])) j++;
        for (int k = i; k <= j; k++) begin
          if (i == j) c = 4'b0111;
          else        c = {1'b1, 1'b0, (k == j), (k == i)};
          w[k*DW_LINE +: DW_LINE] = {c, rw[k*DW_ROW +: DW_ROW], dt[k*DW_DATA +: DW_DATA]};
        end
        i = j + 1;
      end
    end
    return w;
  endfunction

  function automatic logic [NUM_IN-1:0] ref_mask(input logic [W_BEAT-1:0] w);
    logic [NUM_IN-1:0] m;
    for (int k = 0; k < NUM_IN; k++) m[k] = w[k*DW_LINE + DW_DATA + DW_ROW + 2];
    return m;
  endfunction

  function automatic logic m_ready();
    return (m_st == M_RUN) && (q.size() < FIFO_DEPTH);
  endfunction

  function automatic logic m_out_valid();
    return (q.size() > 0) && (q[0].rdy <= now);
  endfunction

  task automatic model_reset();
    q.delete();
    m_st       = M_RUN;
    exp_fan_in = '0;
  endtask

  // Advance the model across the next rising edge using the current inputs.
  task automatic model_edge();
    logic acc;
    logic pop;
    int   sz_pre;
    logic [W_BEAT-1:0] w;
    acc    = in_valid && m_ready();
    pop    = out_ready && m_out_valid();
    sz_pre = q.size();
    w      = ref_line(in_lane_valid, in_row, in_data);
    if (pop) void'(q.pop_front());
    if (acc) q.push_back('{rdy: now + 2 + LATENCY, word: w});
    exp_fan_in = acc ? w : '0;
    case (m_st)
      M_RUN:   m_st = flush ? M_DRAIN : M_RUN;
      M_DRAIN: m_st = (sz_pre == 0) ? M_DONE : M_DRAIN;
      default: m_st = M_RUN;
    endcase
    now++;
  endtask

  task automatic chk_vec(input string tag, input logic [W_BEAT-1:0] got, input logic [W_BEAT-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (edge %0d)", tag, got, exp, now);
    end
  endtask

  task automatic check_all();
    chk_vec("in_ready",   W_BEAT'(in_ready),   W_BEAT'(m_ready()));
    chk_vec("out_valid",  W_BEAT'(out_valid),  W_BEAT'(m_out_valid()));
    chk_vec("busy",       W_BEAT'(busy),       W_BEAT'(q.size() != 0));
    chk_vec("flush_done", W_BEAT'(flush_done), W_BEAT'(m_st == M_DONE));
    chk_vec("fan_in",     fan_in,              exp_fan_in);
    if (m_out_valid()) begin
      chk_vec("out_line", out_line,           q[0].word);
      chk_vec("out_mask", W_BEAT'(out_mask),  W_BEAT'(ref_mask(q[0].word)));
    end
  endtask

  task automatic run_cycle();
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic rand_beat();
    in_lane_valid = NUM_IN'($urandom());
    for (int k = 0; k < NUM_IN; k++) begin
      in_row[k*DW_ROW +: DW_ROW]    = DW_ROW'($urandom_range(0, 2));
      in_data[k*DW_DATA +: DW_DATA] = DW_DATA'($urandom());
    end
  endtask

  logic [3:0] tv1 [NUM_IN];
  logic [3:0] tv2 [NUM_IN];
  int         first_edge;
  int         acc_edge;
  int         n_acc;
  int         n_pulse;

  initial begin
    tv1 = '{4'b1001, 4'b1010, 4'b1001, 4'b1000, 4'b1010, 4'b0111, 4'b1001, 4'b1010};
    tv2 = '{4'b0000, 4'b1001, 4'b1010, 4'b0000, 4'b1001, 4'b1000, 4'b1000, 4'b1010};
    n_vec = 0; n_err = 0; now = 0;
    rst = 1'b1; in_valid = 1'b0; in_lane_valid = '0; in_row = '0; in_data = '0;
    out_ready = 1'b0; flush = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_all();
    chk_vec("rst_out_line", out_line, '0);
    chk_vec("rst_out_mask", W_BEAT'(out_mask), '0);

    // Segment vector 1: rows {0,0,1,1,1,2,3,3}, data 1..8.
    out_ready     = 1'b1;
    in_valid      = 1'b1;
    in_lane_valid = 8'hFF;
    in_row        = {4'd3, 4'd3, 4'd2, 4'd1, 4'd1, 4'd1, 4'd0, 4'd0};
    in_data       = {8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
    run_cycle();
    for (int k = 0; k < NUM_IN; k++)
      chk_vec($sformatf("tv1_ctrl%0d", k), W_BEAT'(fan_in[k*DW_LINE + DW_DATA + DW_ROW +: 4]), W_BEAT'(tv1[k]));

    // Segment vector 2: holes at lanes 0 and 3, all rows 5.
    in_lane_valid = 8'b1111_0110;
    in_row        = {8{4'd5}};
    in_data       = {8'hF8, 8'hF7, 8'hF6, 8'hF5, 8'hF4, 8'hF3, 8'hF2, 8'hF1};
    run_cycle();
    for (int k = 0; k < NUM_IN; k++)
      chk_vec($sformatf("tv2_ctrl%0d", k), W_BEAT'(fan_in[k*DW_LINE + DW_DATA + DW_ROW +: 4]), W_BEAT'(tv2[k]));
    chk_vec("tv2_lane0_zero", W_BEAT'(fan_in[0 +: DW_LINE]), '0);
    chk_vec("tv2_lane3_zero", W_BEAT'(fan_in[3*DW_LINE +: DW_LINE]), '0);
    in_valid = 1'b0;

    // Single beat accepted at edge 10 must surface LATENCY+1 edges later.
    for (int c = 0; c < 20 && now < 9; c++) run_cycle();
    rand_beat();
    in_lane_valid = 8'hFF;
    in_valid = 1'b1;
    run_cycle();
    in_valid = 1'b0;
    acc_edge = now;
    first_edge = -1;
    for (int c = 0; c < 12; c++) begin
      run_cycle();
      if ((out_valid === 1'b1) && (first_edge < 0)) first_edge = now;
    end
    chk_vec("latency", W_BEAT'(first_edge), W_BEAT'(acc_edge + 1 + LATENCY));

    // Backpressure: no pops, continuous offers -> FIFO_DEPTH accepts only.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    n_acc     = 0;
    for (int c = 0; c < 10; c++) begin
      rand_beat();
      if (in_ready === 1'b1) n_acc++;
      run_cycle();
    end
    chk_vec("bp_accepts", W_BEAT'(n_acc), W_BEAT'(FIFO_DEPTH));
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 10; c++) run_cycle();

    // Flush with two beats outstanding.
    in_valid = 1'b1;
    rand_beat(); run_cycle();
    rand_beat(); run_cycle();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    flush     = 1'b1;
    run_cycle();
    flush = 1'b0;
    chk_vec("drain_ready", W_BEAT'(in_ready), '0);
    n_pulse = 0;
    for (int c = 0; c < 30; c++) begin
      if (c == 3) out_ready = 1'b1;
      run_cycle();
      if (flush_done === 1'b1) n_pulse++;
    end
    chk_vec("flush_pulses", W_BEAT'(n_pulse), W_BEAT'(1));

    // Flush with nothing in flight still pulses once.
    flush = 1'b1;
    run_cycle();
    flush = 1'b0;
    n_pulse = 0;
    for (int c = 0; c < 6; c++) begin
      run_cycle();
      if (flush_done === 1'b1) n_pulse++;
    end
    chk_vec("idle_flush_pulses", W_BEAT'(n_pulse), W_BEAT'(1));

    // Asynchronous reset with one result in the FIFO and three in flight.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int c = 0; c < FIFO_DEPTH; c++) begin
      rand_beat();
      run_cycle();
    end
    in_valid = 1'b0;
    run_cycle();
    chk_vec("pre_rst_valid", W_BEAT'(out_valid), W_BEAT'(1));
    #2;
    rst = 1'b1;
    #1;
    chk_vec("rst_async_valid", W_BEAT'(out_valid), '0);
    chk_vec("rst_async_busy",  W_BEAT'(busy), '0);
    chk_vec("rst_async_fan",   fan_in, '0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    check_all();
    out_ready = 1'b1;
    for (int c = 0; c < 12; c++) run_cycle();

    // Randomized traffic against the model.
    for (int c = 0; c < 800; c++) begin
      rand_beat();
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 39) == 0);
      run_cycle();
    end
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 20; c++) run_cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
